seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_glyph_decode.sv | 38 +++
 rtl/seg7_scan_decoder.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph codes, special
// nibble codes and the output-stage state encoding.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Alternate renderings some displays use for 6, 7 and 9
  localparam logic [6:0] GLYPH_ALT_6 = 7'h1F;
  localparam logic [6:0] GLYPH_ALT_7 = 7'h72;
  localparam logic [6:0] GLYPH_ALT_9 = 7'h73;

  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam logic [3:0] ERR_CODE   = 4'hF;

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } out_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational seven-segment glyph to BCD nibble decoder.
// Define SEG7_ALT_GLYPH_EN to also accept the alternate 6/7/9 glyphs.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = ERR_CODE;
    err    = 1'b1;
    case (glyph)
      GLYPH_0:     begin nibble = 4'd0;       err = 1'b0; end
      GLYPH_1:     begin nibble = 4'd1;       err = 1'b0; end
      GLYPH_2:     begin nibble = 4'd2;       err = 1'b0; end
      GLYPH_3:     begin nibble = 4'd3;       err = 1'b0; end
      GLYPH_4:     begin nibble = 4'd4;       err = 1'b0; end
      GLYPH_5:     begin nibble = 4'd5;       err = 1'b0; end
      GLYPH_6:     begin nibble = 4'd6;       err = 1'b0; end
      GLYPH_7:     begin nibble = 4'd7;       err = 1'b0; end
      GLYPH_8:     begin nibble = 4'd8;       err = 1'b0; end
      GLYPH_9:     begin nibble = 4'd9;       err = 1'b0; end
      GLYPH_BLANK: begin nibble = BLANK_CODE; err = 1'b0; end
`ifdef SEG7_ALT_GLYPH_EN
      GLYPH_ALT_6: begin nibble = 4'd6;       err = 1'b0; end
      GLYPH_ALT_7: begin nibble = 4'd7;       err = 1'b0; end
      GLYPH_ALT_9: begin nibble = 4'd9;       err = 1'b0; end
`endif
      default: begin
        nibble = ERR_CODE;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed seven-segment scan into debounced BCD frames with a
// valid/ready output stage. Glyph set widens with SEG7_ALT_GLYPH_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  logic [6:0]              seg_q, seg_d, seg_prev_q, seg_prev_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d, sel_prev_q, sel_prev_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] coll_bcd_q, coll_bcd_d;
  logic [NUM_DIGITS-1:0]   coll_err_q, coll_err_d;

  logic                    sel_onehot;
  logic                    capture;
  logic                    frame_done;
  logic [3:0]              glyph_nibble;
  logic                    glyph_err;

  out_state_e              state_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   err_q;
  logic                    frame_valid_q;
  logic                    overrun_q;

  seg7_glyph_decode u_decode (
    .glyph  (seg_q),
    .nibble (glyph_nibble),
    .err    (glyph_err)
  );

  always_comb begin
    seg_d      = seg_in;
    sel_d      = dig_sel;
    seg_prev_d = seg_q;
    sel_prev_d = sel_q;

    sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);

    if (!sel_onehot || (seg_q != seg_prev_q) || (sel_q != sel_prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q < STABLE_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    capture    = (cnt_q == STABLE_MAX - 4'd1) && (cnt_d == STABLE_MAX);
    frame_done = &mask_q;

    // A capture landing in the clearing cycle starts the next frame's mask
    mask_d     = frame_done ? '0 : mask_q;
    coll_bcd_d = coll_bcd_q;
    coll_err_d = coll_err_q;
    if (capture) begin
      mask_d = mask_d | sel_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_q[i]) begin
          coll_bcd_d[4*i +: 4] = glyph_nibble;
          coll_err_d[i]        = glyph_err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q      <= '0;
      sel_q      <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      coll_bcd_q <= '0;
      coll_err_q <= '0;
    end else begin
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      seg_prev_q <= seg_prev_d;
      sel_prev_q <= sel_prev_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      coll_bcd_q <= coll_bcd_d;
      coll_err_q <= coll_err_d;
    end
  end

  // Output stage: a presented frame is frozen until accepted; later frames drop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      bcd_q         <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (frame_done) begin
            bcd_q         <= coll_bcd_q;
            err_q         <= coll_err_q;
            frame_valid_q <= 1'b1;
            state_q       <= PRESENT;
          end
        end
        PRESENT: begin
          if (frame_ready) begin
            if (frame_done) begin
              bcd_q         <= coll_bcd_q;
              err_q         <= coll_err_q;
              frame_valid_q <= 1'b1;
            end else begin
              frame_valid_q <= 1'b0;
              state_q       <= EMPTY;
            end
          end else if (frame_done) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          frame_valid_q <= 1'b0;
          state_q       <= EMPTY;
        end
      endcase
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder with default parameters.
// Expected values for the alternate glyphs follow SEG7_ALT_GLYPH_EN.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  int checkCount = 0;
  int passCount  = 0;
  bit seen;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Called on a falling edge; holds the pattern for 'hold' rising edges
  task automatic applyStimulus(input logic [6:0] glyph, input logic [3:0] sel, input int hold);
    seg_in  = glyph;
    dig_sel = sel;
    repeat (hold) @(negedge clk);
  endtask

  task automatic sendDigit(input logic [6:0] glyph, input int digit);
    applyStimulus(glyph, 4'(1 << digit), 4);
  endtask

  task automatic sendFrame(input logic [6:0] g0, input logic [6:0] g1,
                           input logic [6:0] g2, input logic [6:0] g3);
    sendDigit(g0, 0);
    sendDigit(g1, 1);
    sendDigit(g2, 2);
    sendDigit(g3, 3);
    applyStimulus(7'h00, 4'b0000, 1);
  endtask

  task automatic waitValid(input int maxCycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    seg_in      = 7'h00;
    dig_sel     = 4'b0000;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid",   32'(frame_valid), 32'h0);
    checkOutput("reset_overrun", 32'(overrun),     32'h0);
    checkOutput("reset_bcd",     32'(bcd_out),     32'h0);
    checkOutput("reset_err",     32'(digit_err),   32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame 0,1,2,3 with the consumer always ready
    frame_ready = 1'b1;
    sendFrame(7'h7E, 7'h30, 7'h6D, 7'h79);
    waitValid(10, seen);
    checkOutput("basic_seen", 32'(seen),      32'h1);
    checkOutput("basic_bcd",  32'(bcd_out),   32'h3210);
    checkOutput("basic_err",  32'(digit_err), 32'h0);
    @(negedge clk);
    checkOutput("basic_one_cycle", 32'(frame_valid), 32'h0);

    // Last digit held only 3 samples: no capture, then 4 samples completes it
    sendDigit(7'h5B, 0);
    sendDigit(7'h5F, 1);
    sendDigit(7'h70, 2);
    applyStimulus(7'h7F, 4'b1000, 3);
    applyStimulus(7'h00, 4'b0000, 1);
    waitValid(12, seen);
    checkOutput("short_hold_no_frame", 32'(seen), 32'h0);
    sendDigit(7'h7F, 3);
    applyStimulus(7'h00, 4'b0000, 1);
    waitValid(10, seen);
    checkOutput("long_hold_seen", 32'(seen),    32'h1);
    checkOutput("long_hold_bcd",  32'(bcd_out), 32'h8765);
    @(negedge clk);

    // Non-one-hot strobes never advance the counter or capture
    sendDigit(7'h7B, 1);
    sendDigit(7'h7B, 2);
    sendDigit(7'h7B, 3);
    applyStimulus(7'h7E, 4'b0011, 8);
    checkOutput("multi_sel_cnt", 32'(dut.cnt_q), 32'h0);
    applyStimulus(7'h7E, 4'b0000, 8);
    checkOutput("zero_sel_cnt", 32'(dut.cnt_q), 32'h0);
    checkOutput("bad_sel_no_frame", 32'(frame_valid), 32'h0);
    sendDigit(7'h30, 0);
    applyStimulus(7'h00, 4'b0000, 1);
    waitValid(10, seen);
    checkOutput("bad_sel_seen", 32'(seen),      32'h1);
    checkOutput("bad_sel_bcd",  32'(bcd_out),   32'h9991);
    checkOutput("bad_sel_err",  32'(digit_err), 32'h0);
    @(negedge clk);

    // Blank plus the alternate glyphs
    sendFrame(7'h00, 7'h72, 7'h1F, 7'h73);
    waitValid(10, seen);
    checkOutput("alt_seen", 32'(seen), 32'h1);
`ifdef SEG7_ALT_GLYPH_EN
    checkOutput("alt_bcd", 32'(bcd_out),   32'h967A);
    checkOutput("alt_err", 32'(digit_err), 32'h0);
`else
    checkOutput("alt_bcd", 32'(bcd_out),   32'hFFFA);
    checkOutput("alt_err", 32'(digit_err), 32'hE);
`endif
    @(negedge clk);
    checkOutput("alt_consumed", 32'(frame_valid), 32'h0);

    // Consumer stalled across two frames: first held, second dropped
    frame_ready = 1'b0;
    sendFrame(7'h33, 7'h5B, 7'h7F, 7'h7B);
    waitValid(10, seen);
    checkOutput("stall_seen",        32'(seen),    32'h1);
    checkOutput("stall_bcd",         32'(bcd_out), 32'h9854);
    checkOutput("stall_no_overrun",  32'(overrun), 32'h0);
    sendFrame(7'h7E, 7'h7E, 7'h7E, 7'h7E);
    repeat (4) @(negedge clk);
    checkOutput("stall_valid_held", 32'(frame_valid), 32'h1);
    checkOutput("stall_bcd_held",   32'(bcd_out),     32'h9854);
    checkOutput("stall_overrun",    32'(overrun),     32'h1);
    frame_ready = 1'b1;
    checkOutput("stall_deliver_bcd", 32'(bcd_out), 32'h9854);
    @(negedge clk);
    checkOutput("stall_accepted",       32'(frame_valid), 32'h0);
    checkOutput("stall_overrun_sticky", 32'(overrun),     32'h1);

    // Mid-frame reset discards the partial frame and clears overrun
    sendDigit(7'h7E, 0);
    sendDigit(7'h30, 1);
    applyStimulus(7'h00, 4'b0000, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset_overrun", 32'(overrun),     32'h0);
    checkOutput("midreset_valid",   32'(frame_valid), 32'h0);
    checkOutput("midreset_bcd",     32'(bcd_out),     32'h0);
    sendDigit(7'h79, 2);
    sendDigit(7'h6D, 3);
    applyStimulus(7'h00, 4'b0000, 1);
    waitValid(12, seen);
    checkOutput("midreset_partial_dropped", 32'(seen), 32'h0);
    sendDigit(7'h5F, 0);
    sendDigit(7'h70, 1);
    applyStimulus(7'h00, 4'b0000, 1);
    waitValid(10, seen);
    checkOutput("midreset_seen",    32'(seen),    32'h1);
    checkOutput("midreset_new_bcd", 32'(bcd_out), 32'h2376);
    checkOutput("midreset_no_overrun", 32'(overrun), 32'h0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
